// File: rtl/adder_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_if
// Description : Operand/result bundle for the adder.
//               master : drives a_i, b_i, carryin_i; receives the sum.
//               slave  : the adder itself.
//   a_i        DATAWIDTH  operand A
//   b_i        DATAWIDTH  operand B
//   carryin_i  1          carry-in, weight 1
//   result_o   DATAWIDTH  sum bits [DATAWIDTH-1:0]
//   carryout_o 1          carry out of the MSB
//   overflow_o 1          signed overflow flag
// Revision    : 1.0  initial release
// ============================================================================
interface adder_if #(
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] a_i;
  logic [DATAWIDTH-1:0] b_i;
  logic                 carryin_i;
  logic [DATAWIDTH-1:0] result_o;
  logic                 carryout_o;
  logic                 overflow_o;

  modport master (
    output a_i,
    output b_i,
    output carryin_i,
    input  result_o,
    input  carryout_o,
    input  overflow_o
  );

  modport slave (
    input  a_i,
    input  b_i,
    input  carryin_i,
    output result_o,
    output carryout_o,
    output overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : result = a + b + cin with carry-out and signed overflow.
//               PIPELINE=0 : outputs are a pure combinational function of the
//                            operands; clk_i/rst_ni are ignored.
//               PIPELINE=1 : outputs registered on the rising clk_i edge,
//                            cleared asynchronously while rst_ni is low.
//   clk_i   in  1       clock (registered build only)
//   rst_ni  in  1       asynchronous active-low reset (registered build only)
//   bus     slave       operands in, result/carryout/overflow out
// Revision    : 1.0  initial release
// ============================================================================
module adder #(
  parameter int DATAWIDTH = 8,
  parameter int PIPELINE  = 0
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  adder_if.slave    bus
);

  localparam int c_msb = DATAWIDTH - 1;

  // One bit wider than the operands so the carry is never truncated away.
  logic [DATAWIDTH:0] w_sum;
  logic               w_overflow;

  assign w_sum = {1'b0, bus.a_i} + {1'b0, bus.b_i}
               + {{DATAWIDTH{1'b0}}, bus.carryin_i};

  // Operands agree in sign but the truncated result does not.
  assign w_overflow = (bus.a_i[c_msb] == bus.b_i[c_msb])
                   && (w_sum[c_msb] != bus.a_i[c_msb]);

  generate
    if (PIPELINE == 0) begin : g_comb
      // Clock and reset have no role in the combinational build.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = &{1'b0, clk_i, rst_ni};

      assign bus.result_o   = w_sum[c_msb:0];
      assign bus.carryout_o = w_sum[DATAWIDTH];
      assign bus.overflow_o = w_overflow;
    end else begin : g_pipe
      logic [DATAWIDTH-1:0] r_result;
      logic                 r_carryout;
      logic                 r_overflow;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_result   <= '0;
          r_carryout <= 1'b0;
          r_overflow <= 1'b0;
        end else begin
          r_result   <= w_sum[c_msb:0];
          r_carryout <= w_sum[DATAWIDTH];
          r_overflow <= w_overflow;
        end
      end

      assign bus.result_o   = r_result;
      assign bus.carryout_o = r_carryout;
      assign bus.overflow_o = r_overflow;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder
// Description : Self-checking bench for adder, combinational and registered
//               builds side by side, against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  adder_if #(.DATAWIDTH(W)) bus_c ();
  adder_if #(.DATAWIDTH(W)) bus_p ();

  adder #(.DATAWIDTH(W), .PIPELINE(0)) dut_comb (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_c)
  );

  adder #(.DATAWIDTH(W), .PIPELINE(1)) dut_pipe (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_p)
  );

  // Reference: {carry, overflow, result} from plain integer arithmetic.
  // Overflow = true signed sum outside the 8-bit two's-complement range.
  function automatic logic [9:0] ref_sum(input int a, input int b, input int cin);
    int         s;
    int         sa;
    int         sb;
    int         ss;
    logic [7:0] res;
    logic       co;
    logic       ov;
    s   = a + b + cin;
    res = 8'(s % 256);
    co  = (s >= 256);
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    ss  = sa + sb + cin;
    ov  = (ss > 127) || (ss < -128);
    return {co, ov, res};
  endfunction

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [9:0] exp;
  } vec_t;

  task automatic test_reset();
    logic [9:0] got;
    rst_n           = 1'b0;
    bus_p.a_i       = 8'h5A;
    bus_p.b_i       = 8'hC3;
    bus_p.carryin_i = 1'b1;
    bus_c.a_i       = 8'h12;
    bus_c.b_i       = 8'h34;
    bus_c.carryin_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
    compared++;
    if (got !== 10'h000) begin
      mismatched++;
      $display("FAIL reset_pipe: got %h expected %h", got, 10'h000);
    end
    got = {bus_c.carryout_o, bus_c.overflow_o, bus_c.result_o};
    compared++;
    if (got !== {2'b00, 8'h47}) begin
      mismatched++;
      $display("FAIL reset_comb_unaffected: got %h expected %h", got, {2'b00, 8'h47});
    end
  endtask

  task automatic test_directed();
    vec_t       vecs[5];
    logic [9:0] got;
    vecs[0] = '{8'h0F, 8'h00, 1'b1, {1'b0, 1'b0, 8'h10}};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, {1'b1, 1'b0, 8'hFF}};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 8'h00}};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}};
    vecs[4] = '{8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      bus_c.a_i       = vecs[i].a;
      bus_c.b_i       = vecs[i].b;
      bus_c.carryin_i = vecs[i].cin;
      @(negedge clk);
      got = {bus_c.carryout_o, bus_c.overflow_o, bus_c.result_o};
      compared++;
      if (got !== vecs[i].exp) begin
        mismatched++;
        $display("FAIL directed_%0d (a=%h b=%h cin=%b): got {co,ov,res}=%h expected %h",
                 i, vecs[i].a, vecs[i].b, vecs[i].cin, got, vecs[i].exp);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [9:0] got;
    logic [9:0] exp;
    int         errs;
    errs = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        bus_c.a_i       = 8'(a);
        bus_c.b_i       = 8'(b);
        bus_c.carryin_i = 1'b0;
        #1;
        got = {bus_c.carryout_o, bus_c.overflow_o, bus_c.result_o};
        exp = ref_sum(a, b, 0);
        compared++;
        if (got !== exp) begin
          mismatched++;
          errs++;
          if (errs <= 10)
            $display("FAIL exhaustive a=%h b=%h: got %h expected %h", a[7:0], b[7:0], got, exp);
        end
        #1;
      end
    end
  endtask

  task automatic test_random_comb();
    logic [9:0] got;
    logic [9:0] exp;
    int         a;
    int         b;
    int         c;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      c = int'($urandom_range(1, 0));
      bus_c.a_i       = 8'(a);
      bus_c.b_i       = 8'(b);
      bus_c.carryin_i = c[0];
      #2;
      got = {bus_c.carryout_o, bus_c.overflow_o, bus_c.result_o};
      exp = ref_sum(a, b, c);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL random_comb a=%h b=%h cin=%0d: got %h expected %h", a[7:0], b[7:0], c, got, exp);
      end
    end
  endtask

  task automatic test_pipeline_latency();
    logic [9:0] got;
    logic [9:0] prev;
    logic [9:0] exp;
    int         a;
    int         b;
    int         c;
    @(negedge clk);
    rst_n           = 1'b1;
    bus_p.a_i       = 8'd3;
    bus_p.b_i       = 8'd4;
    bus_p.carryin_i = 1'b0;
    @(posedge clk);
    #1;
    got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
    compared++;
    if (got !== {2'b00, 8'd7}) begin
      mismatched++;
      $display("FAIL pipe_first_load: got %h expected %h", got, {2'b00, 8'd7});
    end
    prev = {2'b00, 8'd7};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      c = int'($urandom_range(1, 0));
      bus_p.a_i       = 8'(a);
      bus_p.b_i       = 8'(b);
      bus_p.carryin_i = c[0];
      exp = ref_sum(a, b, c);
      #1;
      got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
      compared++;
      if (got !== prev) begin
        mismatched++;
        $display("FAIL pipe_hold_before_edge: got %h expected %h", got, prev);
      end
      @(posedge clk);
      #1;
      got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL pipe_stream a=%h b=%h cin=%0d: got %h expected %h", a[7:0], b[7:0], c, got, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] got;
    logic [9:0] exp;
    // Make sure the register holds something non-zero first.
    @(negedge clk);
    bus_p.a_i       = 8'h80;
    bus_p.b_i       = 8'h80;
    bus_p.carryin_i = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
    compared++;
    if (got !== 10'h000) begin
      mismatched++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, 10'h000);
    end
    @(posedge clk);
    #1;
    got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
    compared++;
    if (got !== 10'h000) begin
      mismatched++;
      $display("FAIL async_reset_held: got %h expected %h", got, 10'h000);
    end
    @(negedge clk);
    rst_n           = 1'b1;
    bus_p.a_i       = 8'h7F;
    bus_p.b_i       = 8'h01;
    bus_p.carryin_i = 1'b0;
    exp = ref_sum(127, 1, 0);
    @(posedge clk);
    #1;
    got = {bus_p.carryout_o, bus_p.overflow_o, bus_p.result_o};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL reset_release_load: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_random_comb();
    test_pipeline_latency();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
